// File: rtl/cache_refill_unit_if.sv
// Bundle of the refill request, AXI-style read channels, data-RAM write port and completion report.
// The master modport is the refill unit's view; slave is the surrounding system's view.
interface cache_refill_unit_if;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [5:0]   req_index;

    logic         mem_ar_valid;
    logic         mem_ar_ready;
    logic [31:0]  mem_ar_addr;
    logic [7:0]   mem_ar_len;
    logic [2:0]   mem_ar_size;

    logic         mem_r_valid;
    logic         mem_r_ready;
    logic [63:0]  mem_r_data;
    logic         mem_r_last;
    logic [1:0]   mem_r_resp;

    logic         ram_CEN;
    logic         ram_WEN;
    logic [5:0]   ram_A;
    logic [127:0] ram_BWEN;
    logic [127:0] ram_D;

    logic         done_valid;
    logic         done_err;
    logic [127:0] done_data;

    modport master (
        input  req_valid, req_addr, req_index,
        output req_ready,
        output mem_ar_valid, mem_ar_addr, mem_ar_len, mem_ar_size,
        input  mem_ar_ready,
        input  mem_r_valid, mem_r_data, mem_r_last, mem_r_resp,
        output mem_r_ready,
        output ram_CEN, ram_WEN, ram_A, ram_BWEN, ram_D,
        output done_valid, done_err, done_data
    );

    modport slave (
        output req_valid, req_addr, req_index,
        input  req_ready,
        input  mem_ar_valid, mem_ar_addr, mem_ar_len, mem_ar_size,
        output mem_ar_ready,
        output mem_r_valid, mem_r_data, mem_r_last, mem_r_resp,
        input  mem_r_ready,
        input  ram_CEN, ram_WEN, ram_A, ram_BWEN, ram_D,
        input  done_valid, done_err, done_data
    );
endinterface

// File: rtl/cache_refill_unit.sv
// Fetches one 16-byte cache line as a two-beat 64-bit burst, writes it into the data RAM row
// and reports completion; any bus error or malformed burst skips the RAM write.
module cache_refill_unit (
    input  logic                   clk,
    input  logic                   rst,
    cache_refill_unit_if.master    bus
);
    typedef enum logic [2:0] {IDLE, AR, R0, R1, WR, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [5:0]    index_q, index_d;
    logic [127:0]  line_q, line_d;
    logic          err_q, err_d;
    logic [5:0]    ram_a_q, ram_a_d;
    logic [127:0]  ram_d_q, ram_d_d;
    logic          done_err_q, done_err_d;
    logic [127:0]  done_data_q, done_data_d;
    logic          beat_err;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        index_d     = index_q;
        line_d      = line_q;
        err_d       = err_q;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        done_err_d  = done_err_q;
        done_data_d = done_data_q;
        beat_err    = (bus.mem_r_resp != 2'b00);

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr & 32'hFFFF_FFF0;
                    index_d = bus.req_index;
                    line_d  = '0;
                    err_d   = 1'b0;
                    state_d = AR;
                end
            end
            AR: begin
                if (bus.mem_ar_ready) state_d = R0;
            end
            R0: begin
                if (bus.mem_r_valid) begin
                    line_d[63:0] = bus.mem_r_data;
                    // A last flag on the first beat means the burst was truncated.
                    err_d        = err_q | beat_err | bus.mem_r_last;
                    state_d      = bus.mem_r_last ? DONE : R1;
                end
            end
            R1: begin
                if (bus.mem_r_valid) begin
                    line_d[127:64] = bus.mem_r_data;
                    err_d          = err_q | beat_err | ~bus.mem_r_last;
                    state_d        = err_d ? DONE : WR;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // RAM port registers only move on entry to WR so they hold between writes.
        if (state_d == WR) begin
            ram_a_d = index_q;
            ram_d_d = line_d;
        end
        if (state_d == DONE && state_q != DONE) begin
            done_err_d  = err_d;
            done_data_d = line_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            index_q     <= '0;
            line_q      <= '0;
            err_q       <= 1'b0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            done_err_q  <= 1'b0;
            done_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            index_q     <= index_d;
            line_q      <= line_d;
            err_q       <= err_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            done_err_q  <= done_err_d;
            done_data_q <= done_data_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.mem_ar_valid = (state_q == AR);
    assign bus.mem_ar_addr  = addr_q;
    assign bus.mem_ar_len   = 8'd1;
    assign bus.mem_ar_size  = 3'd3;
    assign bus.mem_r_ready  = (state_q == R0) || (state_q == R1);

    assign bus.ram_CEN      = (state_q != WR);
    assign bus.ram_WEN      = (state_q != WR);
    assign bus.ram_BWEN     = {128{state_q != WR}};
    assign bus.ram_A        = ram_a_q;
    assign bus.ram_D        = ram_d_q;

    assign bus.done_valid   = (state_q == DONE);
    assign bus.done_err     = done_err_q;
    assign bus.done_data    = done_data_q;
endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: directed vector table, async-reset sequences
// and randomized refills scored against a burst-level outcome model.
module tb_cache_refill_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   wr_cyc = 0;
    logic [5:0]   wr_a;
    logic [127:0] wr_d;
    logic [127:0] wr_bwen;

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  index;
        int          ar_delay;
        int          gap0;
        int          gap1;
        logic [63:0] beat0;
        logic [63:0] beat1;
        logic [1:0]  resp0;
        logic [1:0]  resp1;
        bit          last0;
        bit          last1;
        bit          hold;
        bit          exp_err;
        bit          exp_wr;
        int          exp_lat;
    } txn_t;

    cache_refill_unit_if bus();

    cache_refill_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.ram_CEN && !bus.ram_WEN) begin
                wr_cnt  = wr_cnt + 1;
                wr_a    = bus.ram_A;
                wr_d    = bus.ram_D;
                wr_bwen = bus.ram_BWEN;
                wr_cyc  = cyc;
            end
            if (bus.done_valid) done_cnt = done_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        logic [127:0] ones;
        ones = {128{1'b1}};
        chk({tag, ".req_ready"},  128'(bus.req_ready), 128'd1);
        chk({tag, ".ar_valid"},   128'(bus.mem_ar_valid), 128'd0);
        chk({tag, ".r_ready"},    128'(bus.mem_r_ready), 128'd0);
        chk({tag, ".CEN"},        128'(bus.ram_CEN), 128'd1);
        chk({tag, ".WEN"},        128'(bus.ram_WEN), 128'd1);
        chk({tag, ".BWEN"},       bus.ram_BWEN, ones);
        chk({tag, ".ram_A"},      128'(bus.ram_A), 128'd0);
        chk({tag, ".ram_D"},      bus.ram_D, 128'd0);
        chk({tag, ".done_valid"}, 128'(bus.done_valid), 128'd0);
        chk({tag, ".done_err"},   128'(bus.done_err), 128'd0);
        chk({tag, ".done_data"},  bus.done_data, 128'd0);
        chk({tag, ".ar_addr"},    128'(bus.mem_ar_addr), 128'd0);
    endtask

    // Outcome of a refill from the burst rules: which beats are consumed, whether the line is
    // good, and how many cycles acceptance-to-completion takes.
    function automatic txn_t model(input txn_t t);
        txn_t r;
        int   beats;
        r       = t;
        beats   = t.last0 ? 1 : 2;
        r.exp_err = (t.resp0 != 2'd0) || t.last0 ||
                    (beats == 2 && ((t.resp1 != 2'd0) || !t.last1));
        r.exp_wr  = !r.exp_err;
        r.exp_lat = 2 + t.ar_delay + t.gap0 + ((beats == 2) ? (1 + t.gap1) : 0) + (r.exp_wr ? 1 : 0);
        return r;
    endfunction

    function automatic txn_t vec(input logic [31:0] addr, input logic [5:0] index,
                                 input int ard, input int g0, input int g1,
                                 input logic [63:0] b0, input logic [63:0] b1,
                                 input logic [1:0] r0, input logic [1:0] r1,
                                 input bit l0, input bit l1, input bit hold,
                                 input bit err, input bit wr, input int lat);
        txn_t t;
        t.addr = addr; t.index = index; t.ar_delay = ard; t.gap0 = g0; t.gap1 = g1;
        t.beat0 = b0; t.beat1 = b1; t.resp0 = r0; t.resp1 = r1;
        t.last0 = l0; t.last1 = l1; t.hold = hold;
        t.exp_err = err; t.exp_wr = wr; t.exp_lat = lat;
        return t;
    endfunction

    task automatic drive_beat(input int gap, input logic [63:0] data, input logic [1:0] resp,
                              input bit last, input string tag);
        for (int i = 0; i <= gap; i++) begin
            bus.mem_r_valid = (i == gap);
            bus.mem_r_data  = data;
            bus.mem_r_resp  = resp;
            bus.mem_r_last  = last;
            if (i == gap) chk({tag, ".r_ready"}, 128'(bus.mem_r_ready), 128'd1);
            @(negedge clk);
        end
        bus.mem_r_valid = 1'b0;
    endtask

    // Entered at (or just after) a falling edge with the DUT expected idle.
    task automatic run_txn(input txn_t t, input int id);
        int           acc;
        int           done_cyc;
        int           n;
        int           wc0;
        int           dc0;
        logic [127:0] exp_line;

        exp_line = {t.last0 ? 64'h0 : t.beat1, t.beat0};
        wc0 = wr_cnt;
        dc0 = done_cnt;
        chk("req_ready_idle", 128'(bus.req_ready), 128'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = t.addr;
        bus.req_index = t.index;
        @(negedge clk);
        acc = cyc;
        bus.req_valid = t.hold;
        chk("busy_req_ready", 128'(bus.req_ready), 128'd0);

        for (int i = 0; i <= t.ar_delay; i++) begin
            bus.mem_ar_ready = (i == t.ar_delay);
            bus.mem_r_valid  = 1'b1;
            bus.mem_r_data   = {$urandom, $urandom};
            bus.mem_r_resp   = 2'd2;
            bus.mem_r_last   = 1'b1;
            chk("ar_valid",   128'(bus.mem_ar_valid), 128'd1);
            chk("ar_r_ready", 128'(bus.mem_r_ready), 128'd0);
            chk("ar_addr",    128'(bus.mem_ar_addr), 128'(t.addr & 32'hFFFF_FFF0));
            if (i == 0) begin
                chk("ar_len",  128'(bus.mem_ar_len), 128'd1);
                chk("ar_size", 128'(bus.mem_ar_size), 128'd3);
            end
            @(negedge clk);
        end
        bus.mem_ar_ready = 1'b0;
        bus.mem_r_valid  = 1'b0;

        drive_beat(t.gap0, t.beat0, t.resp0, t.last0, "beat0");
        if (!t.last0) drive_beat(t.gap1, t.beat1, t.resp1, t.last1, "beat1");

        n = 0;
        while (!bus.done_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 128'(bus.done_valid), 128'd1);
        if (!bus.done_valid) return;
        done_cyc = cyc;
        chk("latency",   128'(done_cyc - acc), 128'(t.exp_lat));
        chk("done_err",  128'(bus.done_err), 128'(t.exp_err));
        chk("done_data", bus.done_data, exp_line);

        @(negedge clk);
        #1;
        chk("ready_after_done", 128'(bus.req_ready), 128'd1);
        chk("done_pulse_1cyc",  128'(bus.done_valid), 128'd0);
        chk("done_data_hold",   bus.done_data, exp_line);
        chk("done_err_hold",    128'(bus.done_err), 128'(t.exp_err));
        chk("done_count",       128'(done_cnt - dc0), 128'd1);
        chk("write_count",      128'(wr_cnt - wc0), 128'(t.exp_wr));
        if (t.exp_wr) begin
            chk("wr_cycle", 128'(wr_cyc), 128'(done_cyc - 1));
            chk("wr_A",     128'(wr_a), 128'(t.index));
            chk("wr_D",     wr_d, exp_line);
            chk("wr_BWEN",  wr_bwen, 128'd0);
            chk("ram_A_hold", 128'(bus.ram_A), 128'(t.index));
        end
        $display("txn %0d addr=%h idx=%0d ard=%0d gaps=%0d/%0d err=%0d wr=%0d lat=%0d", id, t.addr,
                 t.index, t.ar_delay, t.gap0, t.gap1, t.exp_err, t.exp_wr, t.exp_lat);
    endtask

    task automatic reset_mid(input bit in_wr);
        int wc;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_1234;
        bus.req_index = 6'd5;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.mem_ar_ready = 1'b1;
        @(negedge clk);
        bus.mem_ar_ready = 1'b0;
        bus.mem_r_valid  = 1'b1;
        bus.mem_r_data   = 64'h1111_2222_3333_4444;
        bus.mem_r_resp   = 2'd0;
        bus.mem_r_last   = 1'b0;
        @(negedge clk);
        if (in_wr) begin
            bus.mem_r_data = 64'hAAAA_BBBB_CCCC_DDDD;
            bus.mem_r_last = 1'b1;
            @(negedge clk);
            chk("wr_entered", 128'(bus.ram_CEN), 128'd0);
        end else begin
            chk("r1_entered", 128'(bus.mem_r_ready), 128'd1);
        end
        bus.mem_r_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outs(in_wr ? "rst_mid_wr" : "rst_mid_r1");
        wc = wr_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_resume",          128'(bus.req_ready), 128'd1);
        chk("no_write_after_rst", 128'(wr_cnt - wc), 128'd0);
        $display("reset during %s checked", in_wr ? "WR" : "R1");
    endtask

    txn_t tbl[8];
    txn_t rt;

    initial begin
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_index = '0;
        bus.mem_ar_ready = 1'b0;
        bus.mem_r_valid = 1'b0; bus.mem_r_data = '0; bus.mem_r_last = 1'b0; bus.mem_r_resp = '0;

        tbl[0] = vec(32'h8000_1234, 6'd5,  0, 0, 0, 64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD,
                     2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        tbl[1] = vec(32'h1234_5678, 6'd42, 3, 0, 2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9);
        tbl[2] = vec(32'hDEAD_BEEF, 6'd17, 0, 0, 0, 64'h5555_6666_7777_8888, 64'h9999_0000_AAAA_BBBB,
                     2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3);
        tbl[3] = vec(32'h0000_0010, 6'd63, 0, 1, 0, 64'hCAFE_F00D_DEAD_BEEF, 64'h1234_1234_1234_1234,
                     2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3);
        tbl[4] = vec(32'hFFFF_FFFF, 6'd0,  1, 0, 0, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF,
                     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        tbl[5] = vec(32'h4000_0008, 6'd9,  0, 0, 1, 64'h0BAD_0BAD_0BAD_0BAD, 64'h600D_600D_600D_600D,
                     2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4);
        tbl[6] = vec(32'h2222_3330, 6'd33, 0, 0, 0, 64'hA5A5_A5A5_5A5A_5A5A, 64'h3C3C_C3C3_3C3C_C3C3,
                     2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4);
        tbl[7] = vec(32'h3333_4440, 6'd34, 0, 2, 0, 64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0,
                     2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6);

        #2 check_reset_outs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_txn(tbl[k], k);
        bus.req_valid = 1'b0;

        reset_mid(1'b0);
        run_txn(tbl[0], 100);
        reset_mid(1'b1);
        run_txn(tbl[1], 101);

        for (int k = 0; k < 40; k++) begin
            rt.addr     = $urandom;
            rt.index    = 6'($urandom_range(0, 63));
            rt.ar_delay = $urandom_range(0, 3);
            rt.gap0     = $urandom_range(0, 2);
            rt.gap1     = $urandom_range(0, 2);
            rt.beat0    = {$urandom, $urandom};
            rt.beat1    = {$urandom, $urandom};
            rt.resp0    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rt.resp1    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rt.last0    = ($urandom_range(0, 9) == 0);
            rt.last1    = ($urandom_range(0, 9) != 0);
            rt.hold     = ($urandom_range(0, 3) == 0);
            rt          = model(rt);
            run_txn(rt, 200 + k);
        end
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
